sprite_line_fill: RTL and testbench
===================================

SPRITE_LINE_FILL -- requirements
Module: sprite_line_fill

Interface
REQ-001 SHALL have port clk, input, 1, sole clock; all state changes on its rising edge.
REQ-002 SHALL have port rst, input, 1, asynchronous active-high reset.
REQ-003 SHALL have port start, input, 1, one-cycle request to draw one sprite row; sampled only in IDLE.
REQ-004 SHALL have port size_x, input, 3, sprite width in tiles minus one; latched on accepted start.
REQ-005 SHALL have port x_pos, input, 10, screen x of sprite left edge; latched on accepted start.
REQ-006 SHALL have port palette, input, 4, palette select for the row; latched on accepted start.
REQ-007 SHALL have port abort, input, 1, synchronous cancel of the current row.
REQ-008 SHALL have port load, output, 1, pulse telling the tile table to latch sprite attributes.
REQ-009 SHALL have port current_tile, output, 4, tile index presented to the tile table.
REQ-010 SHALL have port tile_data, input, 32, eight 4-bit pixels returned by the tile table, already flip-corrected, valid one clk after current_tile changes.
REQ-011 SHALL have port lb_we, output, 1, line buffer write strobe.
REQ-012 SHALL have port lb_addr, output, 10, line buffer pixel address.
REQ-013 SHALL have port lb_data, output, 8, pixel value {palette, color}.
REQ-014 SHALL have port busy, output, 1, high in any state except IDLE and DONE.
REQ-015 SHALL have port done, output, 1, one-cycle pulse on row completion.

Function
REQ-016 SHALL implement states IDLE, LOAD, FETCH, DRAW, DONE.
REQ-017 IDLE: start=1 -> latch size_x/x_pos/palette, tile counter=0, go LOAD; start=0 -> stay.
REQ-018 LOAD: load=1 for exactly this cycle, current_tile=0, go FETCH.
REQ-019 FETCH: one wait cycle for the synchronous tile read, no writes, go DRAW with pixel counter p=0.
REQ-020 DRAW: current_tile held constant for all 8 cycles, so tile_data stays stable; p increments 0..7.
REQ-021 DRAW pixel p color = tile_data[31-4p : 28-4p]; pixel 0 is leftmost (MSB nibble).
REQ-022 DRAW address = x_pos + 8*current_tile + p, computed at 11 bits, no truncation.
REQ-023 lb_we=1 in a DRAW cycle only if color != 0 (transparent) and 11-bit address < 640; lb_addr/lb_data combinational from the same cycle.
REQ-024 DRAW with p=7: if current_tile == size_x go DONE; else current_tile+1, go FETCH.
REQ-025 DONE: done=1 for one cycle, go IDLE; start in DONE ignored.
REQ-026 Row latency: start at cycle 0 -> load at cycle 1, first DRAW at cycle 3, done at cycle 2 + 9*(size_x+1) + 1.
REQ-027 start while busy SHALL be ignored; latched parameters SHALL not change mid-row.
REQ-028 abort=1 in any non-IDLE state -> IDLE next cycle, lb_we=0 that cycle, no done pulse; abort has priority over start and over all other transitions.
REQ-029 size_x=0 SHALL draw exactly one tile (8 pixel slots); size_x=7 SHALL draw 8 tiles, current_tile 0..7.
REQ-030 lb_we, load, done SHALL never be high in the same cycle.

Reset
REQ-031 rst=1 SHALL immediately force IDLE, load=0, current_tile=0, lb_we=0, lb_addr=0, lb_data=0, busy=0, done=0, counters and latched parameters 0, regardless of clk.
REQ-032 Reset mid-row SHALL drop the row with no further writes and no done; first start after rst deasserts behaves per REQ-017.

Verification
REQ-033 size_x=0, x_pos=100, palette=5, tile_data=0x12345678 -> load at cycle 1, writes at addr 100..107 with data 0x51..0x58, done at cycle 12.
REQ-034 size_x=1, tile_data=0x10203040 for both tiles, x_pos=0 -> writes only addrs 0,2,4,6,8,10,12,14; current_tile 0 then 1; done at cycle 21.
REQ-035 x_pos=636, size_x=0, tile_data=0xFFFFFFFF -> writes at 636..639 only; no write for addresses 640..643; done still pulses.
REQ-036 abort asserted in DRAW at p=3 of tile 0 -> no write that cycle or after, busy=0 next cycle, done never pulses; new start accepted next cycle.
REQ-037 rst asserted asynchronously mid-DRAW -> all outputs 0 before next clk edge; start pulsed while busy -> ignored, no parameter change.

Source files
------------

// File: rtl/sprite_line_fill.sv
// Renders one sprite row into a line buffer. It fetches each tile of the row once and then writes 8 pixels per tile.
// Latency: done pulses 2 + 9*(size_x+1) + 1 cycles after start. Transparent or off-screen pixels are skipped; abort cancels the row.
module sprite_line_fill (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic [2:0]  size_x,
  input  logic [9:0]  x_pos,
  input  logic [3:0]  palette,
  input  logic        abort,
  output logic        load,
  output logic [3:0]  current_tile,
  input  logic [31:0] tile_data,
  output logic        lb_we,
  output logic [9:0]  lb_addr,
  output logic [7:0]  lb_data,
  output logic        busy,
  output logic        done
);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_LOAD  = 3'd1,
    S_FETCH = 3'd2,
    S_DRAW  = 3'd3,
    S_DONE  = 3'd4
  } state_t;

  state_t      state, state_nxt;
  logic [2:0]  size_q;
  logic [9:0]  xpos_q;
  logic [3:0]  pal_q;
  logic [3:0]  tile_q;
  logic [2:0]  pix_q;
  logic        done_q;

  logic        latch;
  logic        tile_inc;
  logic        pix_inc;
  logic        draw;
  logic [31:0] shifted;
  logic [3:0]  color;
  logic [10:0] addr_full;

  always_comb begin
    state_nxt = state;
    latch     = 1'b0;
    tile_inc  = 1'b0;
    pix_inc   = 1'b0;
    load      = 1'b0;
    draw      = 1'b0;
    case (state)
      S_IDLE: begin
        if (start) begin
          latch     = 1'b1;
          state_nxt = S_LOAD;
        end
      end
      S_LOAD: begin
        load      = 1'b1;
        state_nxt = S_FETCH;
      end
      S_FETCH: state_nxt = S_DRAW;
      S_DRAW: begin
        draw    = 1'b1;
        pix_inc = 1'b1;
        if (pix_q == 3'd7) begin
          if (tile_q == {1'b0, size_q}) begin
            state_nxt = S_DONE;
          end else begin
            tile_inc  = 1'b1;
            state_nxt = S_FETCH;
          end
        end
      end
      S_DONE:  state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
    // Abort beats every other transition, including a start seen in IDLE.
    if (abort) begin
      state_nxt = S_IDLE;
      latch     = 1'b0;
      tile_inc  = 1'b0;
      pix_inc   = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state  <= S_IDLE;
      size_q <= '0;
      xpos_q <= '0;
      pal_q  <= '0;
      tile_q <= '0;
      pix_q  <= '0;
      done_q <= 1'b0;
    end else begin
      state  <= state_nxt;
      done_q <= (state == S_DONE) && !abort;
      if (latch) begin
        size_q <= size_x;
        xpos_q <= x_pos;
        pal_q  <= palette;
        tile_q <= '0;
        pix_q  <= '0;
      end else begin
        if (tile_inc) tile_q <= tile_q + 4'd1;
        if (pix_inc)  pix_q  <= pix_q + 3'd1;
      end
    end
  end

  // The leftmost pixel sits in the top nibble, so shift the nibble for pixel p up into [31:28].
  assign shifted   = tile_data << {pix_q, 2'b00};
  assign color     = shifted[31:28];
  assign addr_full = {1'b0, xpos_q} + {4'b0000, tile_q, 3'b000} + {8'b0, pix_q};

  assign lb_we        = draw && !abort && (color != 4'd0) && (addr_full < 11'd640);
  assign lb_addr      = draw ? addr_full[9:0] : 10'd0;
  assign lb_data      = draw ? {pal_q, color} : 8'd0;
  assign current_tile = tile_q;
  assign busy         = (state == S_LOAD) || (state == S_FETCH) || (state == S_DRAW);
  assign done         = done_q;

endmodule

// File: tb/tb_sprite_line_fill.sv
// Bench for sprite_line_fill: emulates the tile table and checks each row against a pixel-level model.
module tb_sprite_line_fill;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic [2:0]  size_x;
  logic [9:0]  x_pos;
  logic [3:0]  palette;
  logic        abort;
  logic        load;
  logic [3:0]  current_tile;
  logic [31:0] tile_data;
  logic        lb_we;
  logic [9:0]  lb_addr;
  logic [7:0]  lb_data;
  logic        busy;
  logic        done;

  int errors = 0;
  int checks = 0;
  logic [31:0] tile_mem [16];

  always #5 clk = ~clk;

  // Tile table: synchronous read, data valid one cycle after current_tile changes.
  always @(posedge clk) tile_data <= tile_mem[current_tile];

  sprite_line_fill dut (
    .clk(clk), .rst(rst), .start(start), .size_x(size_x), .x_pos(x_pos),
    .palette(palette), .abort(abort), .load(load), .current_tile(current_tile),
    .tile_data(tile_data), .lb_we(lb_we), .lb_addr(lb_addr), .lb_data(lb_data),
    .busy(busy), .done(done)
  );

  task automatic check_all_zero(input string tag);
    checks++; if (load !== 1'b0) begin errors++; $display("FAIL %s load got=%b exp=0", tag, load); end
    checks++; if (current_tile !== 4'd0) begin errors++; $display("FAIL %s current_tile got=%0d exp=0", tag, current_tile); end
    checks++; if (lb_we !== 1'b0) begin errors++; $display("FAIL %s lb_we got=%b exp=0", tag, lb_we); end
    checks++; if (lb_addr !== 10'd0) begin errors++; $display("FAIL %s lb_addr got=%0d exp=0", tag, lb_addr); end
    checks++; if (lb_data !== 8'd0) begin errors++; $display("FAIL %s lb_data got=%h exp=00", tag, lb_data); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL %s busy got=%b exp=0", tag, busy); end
    checks++; if (done !== 1'b0) begin errors++; $display("FAIL %s done got=%b exp=0", tag, done); end
  endtask

  // Entered and left 1 time unit after a rising edge; start is driven in that cycle (cycle 0).
  // Parameter inputs are scrambled every cycle and start is re-pulsed while busy and in DONE.
  task automatic run_row(input logic [2:0] sx, input logic [9:0] x, input logic [3:0] pal, input string tag);
    logic [29:0] exp_q[$];
    logic [29:0] obs_q[$];
    logic [31:0] w;
    logic [3:0]  c;
    int n, done_cyc, a, m;
    n = int'(sx) + 1;
    done_cyc = 2 + 9 * n + 1;
    for (int tt = 0; tt < n; tt++) begin
      for (int p = 0; p < 8; p++) begin
        w = tile_mem[tt] >> (28 - 4 * p);
        c = w[3:0];
        a = int'(x) + 8 * tt + p;
        if (c != 4'd0 && a < 640) exp_q.push_back({12'(3 + 9 * tt + p), 10'(a), pal, c});
      end
    end
    start = 1'b1; size_x = sx; x_pos = x; palette = pal;
    for (int cyc = 1; cyc <= done_cyc; cyc++) begin
      @(posedge clk); #1;
      start = 1'b0;
      size_x = 3'($urandom); x_pos = 10'($urandom); palette = 4'($urandom);
      if (cyc == 5 || cyc == done_cyc - 1) start = 1'b1;
      checks++; if (load !== (cyc == 1)) begin errors++; $display("FAIL %s load cyc=%0d got=%b exp=%b", tag, cyc, load, cyc == 1); end
      checks++; if (done !== (cyc == done_cyc)) begin errors++; $display("FAIL %s done cyc=%0d got=%b exp=%b", tag, cyc, done, cyc == done_cyc); end
      checks++; if (busy !== (cyc >= 1 && cyc <= 1 + 9 * n)) begin errors++; $display("FAIL %s busy cyc=%0d got=%b", tag, cyc, busy); end
      if (cyc >= 2 && cyc <= 1 + 9 * n) begin
        checks++;
        if (current_tile !== 4'((cyc - 2) / 9)) begin errors++; $display("FAIL %s current_tile cyc=%0d got=%0d exp=%0d", tag, cyc, current_tile, (cyc - 2) / 9); end
      end
      checks++;
      if ((lb_we && load) || (lb_we && done) || (load && done)) begin errors++; $display("FAIL %s exclusive cyc=%0d we=%b load=%b done=%b", tag, cyc, lb_we, load, done); end
      if (lb_we === 1'b1) obs_q.push_back({12'(cyc), lb_addr, lb_data});
    end
    checks++;
    if (obs_q.size() != exp_q.size()) begin errors++; $display("FAIL %s write_count got=%0d exp=%0d", tag, obs_q.size(), exp_q.size()); end
    m = (obs_q.size() < exp_q.size()) ? obs_q.size() : exp_q.size();
    for (int i = 0; i < m; i++) begin
      checks++;
      if (obs_q[i] !== exp_q[i])
        begin errors++; $display("FAIL %s write%0d got cyc=%0d addr=%0d data=%h exp cyc=%0d addr=%0d data=%h", tag, i,
          obs_q[i][29:18], obs_q[i][17:8], obs_q[i][7:0], exp_q[i][29:18], exp_q[i][17:8], exp_q[i][7:0]); end
    end
  endtask

  task automatic test_reset;
    rst = 1'b1; start = 1'b0; abort = 1'b0; size_x = '0; x_pos = '0; palette = '0;
    for (int i = 0; i < 16; i++) tile_mem[i] = '0;
    #3;
    check_all_zero("reset_async");
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    @(posedge clk); #1;
    check_all_zero("reset_release");
  endtask

  task automatic test_basic;
    tile_mem[0] = 32'h12345678;
    run_row(3'd0, 10'd100, 4'd5, "basic");
  endtask

  task automatic test_transparent;
    tile_mem[0] = 32'h10203040;
    tile_mem[1] = 32'h10203040;
    run_row(3'd1, 10'd0, 4'($urandom), "transparent");
  endtask

  task automatic test_clip;
    tile_mem[0] = 32'hFFFFFFFF;
    run_row(3'd0, 10'd636, 4'($urandom), "clip");
  endtask

  task automatic test_back_to_back;
    for (int i = 0; i < 8; i++) tile_mem[i] = $urandom;
    run_row(3'd7, 10'd0, 4'd9, "b2b_wide");
    run_row(3'd2, 10'd600, 4'd3, "b2b_next");
  endtask

  task automatic test_random;
    logic [9:0] x;
    for (int r = 0; r < 8; r++) begin
      for (int t = 0; t < 8; t++)
        for (int k = 0; k < 8; k++)
          tile_mem[t][4 * k +: 4] = ($urandom_range(0, 3) == 0) ? 4'd0 : 4'($urandom);
      x = ($urandom_range(0, 1) == 1) ? 10'($urandom_range(560, 639)) : 10'($urandom);
      run_row(3'($urandom), x, 4'($urandom), "random");
    end
  endtask

  task automatic test_abort;
    tile_mem[0] = 32'h11111111;
    start = 1'b1; size_x = 3'd1; x_pos = 10'd50; palette = 4'd2;
    for (int cyc = 1; cyc <= 6; cyc++) begin
      @(posedge clk); #1;
      start = 1'b0;
    end
    checks++; if (lb_we !== 1'b1) begin errors++; $display("FAIL abort_pre lb_we got=%b exp=1", lb_we); end
    abort = 1'b1;
    #1;
    checks++; if (lb_we !== 1'b0) begin errors++; $display("FAIL abort_cycle lb_we got=%b exp=0", lb_we); end
    @(posedge clk); #1;
    abort = 1'b0;
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL abort_next busy got=%b exp=0", busy); end
    checks++; if (lb_we !== 1'b0) begin errors++; $display("FAIL abort_next lb_we got=%b exp=0", lb_we); end
    checks++; if (done !== 1'b0) begin errors++; $display("FAIL abort_next done got=%b exp=0", done); end
    tile_mem[0] = 32'hA0B0C0D0;
    run_row(3'd0, 10'd20, 4'd7, "after_abort");
  endtask

  task automatic test_async_reset;
    for (int i = 0; i < 8; i++) tile_mem[i] = 32'hFFFFFFFF;
    start = 1'b1; size_x = 3'd2; x_pos = 10'd10; palette = 4'd6;
    for (int cyc = 1; cyc <= 5; cyc++) begin
      @(posedge clk); #1;
      start = 1'b0;
    end
    checks++; if (lb_we !== 1'b1) begin errors++; $display("FAIL arst_pre lb_we got=%b exp=1", lb_we); end
    #2 rst = 1'b1;
    #1 check_all_zero("arst_mid");
    @(posedge clk); #1;
    rst = 1'b0;
    for (int i = 0; i < 4; i++) begin
      @(posedge clk); #1;
      check_all_zero("arst_after");
    end
    tile_mem[0] = 32'h0F0F0F0F;
    run_row(3'd0, 10'd300, 4'd1, "after_arst");
  endtask

  initial begin
    test_reset();
    test_basic();
    test_transparent();
    test_clip();
    test_back_to_back();
    test_random();
    test_abort();
    test_async_reset();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
